// File: rtl/anf_fl_tex_pkg.sv
// Shared texture format codes, descriptor layout and helpers for the texture read/write paths.
package anf_fl_tex_pkg;

  localparam int unsigned MetaFmtLsb  = 0;
  localparam int unsigned MetaFmtW    = 5;
  localparam int unsigned MetaHExpLsb = 5;
  localparam int unsigned MetaWExpLsb = 9;
  localparam int unsigned MetaExpW    = 4;
  localparam int unsigned MetaBaseLsb = 32;
  localparam int unsigned MetaBaseW   = 32;

  localparam int unsigned TileExp = 4;
  localparam int unsigned PixW    = 24;
  localparam int unsigned OffW    = 26;

  // Format class in fmt[1:0].
  localparam logic [1:0] FcLinear     = 2'b00;
  localparam logic [1:0] FcLinear16   = 2'b01;
  localparam logic [1:0] FcCompressed = 2'b10;
  localparam logic [1:0] FcTiled      = 2'b11;

  localparam logic [4:0] FmtRgb24         = 5'b00000;
  localparam logic [4:0] FmtRgba32        = 5'b00100;
  localparam logic [4:0] FmtRgb565        = 5'b00001;
  localparam logic [4:0] FmtRgba5551      = 5'b00101;
  localparam logic [4:0] FmtRgba4444      = 5'b01001;
  localparam logic [4:0] FmtLa88          = 5'b01101;
  localparam logic [4:0] FmtRgb24Tiled    = 5'b00011;
  localparam logic [4:0] FmtRgba32Tiled   = 5'b00111;
  localparam logic [4:0] FmtRgb565Tiled   = 5'b01011;
  localparam logic [4:0] FmtRgba5551Tiled = 5'b01111;
  localparam logic [4:0] FmtLa88Tiled     = 5'b10111;
  localparam logic [4:0] FmtR8Tiled       = 5'b10011;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Returns {valid, bpp[2:0]}.
  function automatic logic [3:0] fmt_bpp(input logic [4:0] fmt);
    logic [3:0] r;
    case (fmt)
      FmtRgb24, FmtRgb24Tiled:                        r = {1'b1, 3'd3};
      FmtRgba32, FmtRgba32Tiled:                      r = {1'b1, 3'd4};
      FmtRgb565, FmtRgba5551, FmtRgba4444, FmtLa88,
      FmtRgb565Tiled, FmtRgba5551Tiled, FmtLa88Tiled: r = {1'b1, 3'd2};
      FmtR8Tiled:                                     r = {1'b1, 3'd1};
      default:                                        r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic logic fmt_tiled(input logic [4:0] fmt);
    return fmt[1:0] == FcTiled;
  endfunction

  function automatic logic [31:0] bpp_mask(input logic [2:0] bpp);
    logic [31:0] m;
    case (bpp)
      3'd1:    m = 32'h0000_00ff;
      3'd2:    m = 32'h0000_ffff;
      3'd3:    m = 32'h00ff_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/anf_fl_tex_texel_offset.sv
// Texel (x, y) to byte offset for linear and 16x16-tiled layouts; used by both read and write paths.
module anf_fl_tex_texel_offset
  import anf_fl_tex_pkg::*;
#(
  parameter int unsigned COORD_W = 16
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [3:0]         i_w_exp,
  input  logic [4:0]         i_fmt,
  output logic [OffW-1:0]    o_offset
);

  logic [31:0]     w_row;
  logic [15:0]     w_lin;
  logic [15:0]     w_blk;
  logic [PixW-1:0] w_pix;
  logic [OffW-1:0] w_p;
  logic [3:0]      w_bpp;

  // Linear offset wraps at 16 bits to match the sampler.
  assign w_row = 32'(i_y) << i_w_exp;
  assign w_lin = 16'(w_row + 32'(i_x));
  assign w_blk = 16'(((32'(i_y) >> TileExp) << (i_w_exp - 4'(TileExp)))
                     | (32'(i_x) >> TileExp));
  assign w_pix = fmt_tiled(i_fmt) ? {w_blk, i_y[3:0], i_x[3:0]} : PixW'(w_lin);
  assign w_p   = OffW'(w_pix);
  assign w_bpp = fmt_bpp(i_fmt);

  always_comb begin
    case (w_bpp[2:0])
      3'd1:    o_offset = w_p;
      3'd2:    o_offset = w_p << 1;
      3'd3:    o_offset = (w_p << 1) + w_p;
      default: o_offset = w_p << 2;
    endcase
  end

endmodule

// File: rtl/anf_fl_tex_tile_writer.sv
// Texture upload engine: turns a raster-order texel stream into memory writes laid out
// exactly as the texture sampler reads them.
module anf_fl_tex_tile_writer
  import anf_fl_tex_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned COORD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [63:0]       i_tex_meta,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_texel,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic [1:0]        o_wr_size
);

  state_e              r_state, w_state_next;
  logic [4:0]          r_fmt;
  logic [3:0]          r_w_exp, r_h_exp;
  logic [31:0]         r_base;
  logic [2:0]          r_bpp;
  logic [COORD_W-1:0]  r_x, r_y;
  logic                r_done, r_err, r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic [1:0]          r_wr_size;

  logic [4:0]          w_meta_fmt;
  logic [3:0]          w_meta_w_exp, w_meta_h_exp, w_meta_bpp;
  logic                w_meta_ok;
  logic [COORD_W-1:0]  w_x_max, w_y_max;
  logic                w_x_last, w_y_last;
  logic                w_in_ready, w_in_fire, w_wr_fire, w_launch, w_reject, w_finish;
  logic [OffW-1:0]     w_offset;

  assign w_meta_fmt   = i_tex_meta[MetaFmtLsb +: MetaFmtW];
  assign w_meta_h_exp = i_tex_meta[MetaHExpLsb +: MetaExpW];
  assign w_meta_w_exp = i_tex_meta[MetaWExpLsb +: MetaExpW];
  assign w_meta_bpp   = fmt_bpp(w_meta_fmt);
  assign w_meta_ok    = w_meta_bpp[3] && (!fmt_tiled(w_meta_fmt) ||
                        (w_meta_w_exp >= 4'(TileExp) && w_meta_h_exp >= 4'(TileExp)));

  assign w_x_max  = COORD_W'((32'd1 << r_w_exp) - 32'd1);
  assign w_y_max  = COORD_W'((32'd1 << r_h_exp) - 32'd1);
  assign w_x_last = r_x == w_x_max;
  assign w_y_last = r_y == w_y_max;
  assign w_wr_fire = r_wr_valid && i_wr_ready;

  anf_fl_tex_texel_offset #(
    .COORD_W (COORD_W)
  ) u_offset (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_w_exp  (r_w_exp),
    .i_fmt    (r_fmt),
    .o_offset (w_offset)
  );

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_in_fire    = 1'b0;
    w_launch     = 1'b0;
    w_reject     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_meta_ok) begin
            w_launch     = 1'b1;
            w_state_next = StRun;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      StRun: begin
        // One-entry output register: accept whenever it is empty or draining this cycle.
        w_in_ready = !r_wr_valid || i_wr_ready;
        w_in_fire  = w_in_ready && i_in_valid;
        if (w_in_fire && w_x_last && w_y_last) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_wr_fire) begin
          w_finish     = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_fmt      <= '0;
      r_w_exp    <= '0;
      r_h_exp    <= '0;
      r_base     <= '0;
      r_bpp      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_size  <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;
      r_err   <= w_reject;
      if (w_launch) begin
        r_fmt   <= w_meta_fmt;
        r_w_exp <= w_meta_w_exp;
        r_h_exp <= w_meta_h_exp;
        r_base  <= i_tex_meta[MetaBaseLsb +: MetaBaseW];
        r_bpp   <= w_meta_bpp[2:0];
        r_x     <= '0;
        r_y     <= '0;
      end
      if (w_in_fire) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= ADDR_W'(r_base) + ADDR_W'(w_offset);
        r_wr_data  <= i_in_texel & bpp_mask(r_bpp);
        r_wr_size  <= 2'(r_bpp - 3'd1);
        if (!w_x_last) begin
          r_x <= r_x + COORD_W'(1);
        end else if (!w_y_last) begin
          r_x <= '0;
          r_y <= r_y + COORD_W'(1);
        end
      end else if (w_wr_fire) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  assign o_busy     = r_state != StIdle;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_in_ready = w_in_ready;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_size  = r_wr_size;

endmodule

// File: tb/tb_anf_fl_tex_tile_writer.sv
// Directed bench for the texture tile writer with a write-side scoreboard.
module tb_anf_fl_tex_tile_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] tex_meta;
  logic        busy, done, err;
  logic        in_valid, in_ready;
  logic [31:0] in_texel;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  wr_size;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t sb[$];
  int  cyc = 0, wr_cnt = 0, last_wr_cyc = -1, done_cyc = -1, tx_idx = 0, tx_total = 0;
  bit  feed = 1'b0;
  logic [31:0] cur_base = '0;
  int  cur_bpp = 4, cur_wexp = 0;
  bit  cur_tiled = 1'b0;
  logic [31:0] obs_addr [0:1023];
  logic [31:0] held_addr, held_data;
  int  base_cnt;

  always #5 clk = ~clk;

  anf_fl_tex_tile_writer #(
    .ADDR_W  (32),
    .COORD_W (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_tex_meta (tex_meta),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_texel (in_texel),
    .o_wr_valid (wr_valid),
    .i_wr_ready (wr_ready),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_wr_size  (wr_size)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] texel_of(input int i);
    return 32'hF0F0_0000 | (32'(i) * 32'h0001_0307);
  endfunction

  function automatic logic [31:0] exp_mask(input int bpp);
    logic [31:0] m;
    m = '1;
    if (bpp < 4) m = (32'd1 << (8 * bpp)) - 32'd1;
    return m;
  endfunction

  // Raster index -> expected byte address, from the layout definition.
  function automatic logic [31:0] exp_addr(input int i);
    int w, x, y, p;
    w = 1 << cur_wexp;
    x = i % w;
    y = i / w;
    if (cur_tiled) p = ((y / 16) * (w / 16) + x / 16) * 256 + (y % 16) * 16 + (x % 16);
    else           p = i;
    return cur_base + 32'(p * cur_bpp);
  endfunction

  // Observe handshakes mid-cycle, then drive the next inputs just after the edge.
  task automatic tick();
    wr_t e;
    wr_t g;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e.addr = exp_addr(tx_idx);
        e.data = texel_of(tx_idx) & exp_mask(cur_bpp);
        e.size = 2'(cur_bpp - 1);
        sb.push_back(e);
        tx_idx++;
      end
      if (wr_valid && wr_ready) begin
        chk("sb_occupancy", 96'(sb.size() > 0), 96'(1'b1));
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk("wr_beat", 96'({wr_addr, wr_data, wr_size}), 96'(g));
        end
        obs_addr[wr_cnt % 1024] = wr_addr;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (done) done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = feed && (tx_idx < tx_total);
    in_texel = texel_of(tx_idx);
  endtask

  task automatic launch(input logic [4:0] fmt, input logic [3:0] we, input logic [3:0] he,
                        input logic [31:0] base, input bit tiled, input int bpp);
    cur_base    = base;
    cur_bpp     = bpp;
    cur_tiled   = tiled;
    cur_wexp    = int'(we);
    tx_idx      = 0;
    tx_total    = 1 << (int'(we) + int'(he));
    wr_cnt      = 0;
    done_cyc    = -1;
    last_wr_cyc = -1;
    tex_meta    = {base, 19'd0, we, he, fmt};
    start       = 1'b1;
    tick();
    start       = 1'b0;
    feed        = 1'b1;
    in_valid    = 1'b1;
    in_texel    = texel_of(0);
  endtask

  task automatic finish_upload(input int n);
    for (int k = 0; k < 4000 && done_cyc < 0; k++) tick();
    chk("done_seen", 96'(done_cyc >= 0), 96'(1'b1));
    chk("done_latency", 96'(done_cyc), 96'(last_wr_cyc + 1));
    chk("wr_count", 96'(wr_cnt), 96'(n));
    chk("sb_empty", 96'(sb.size()), 96'(0));
    chk("done_pulse", 96'(done), 96'(1'b0));
    chk("busy_cleared", 96'(busy), 96'(1'b0));
    feed = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tex_meta = '0; in_valid = 1'b0; in_texel = '0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flags", 96'({busy, done, err, wr_valid, in_ready}), 96'(5'd0));
    chk("rst_addr", 96'(wr_addr), 96'(0));
    chk("rst_data", 96'(wr_data), 96'(0));
    chk("rst_size", 96'(wr_size), 96'(0));

    // RGBA_32 linear; descriptor churn and a stray start mid-upload must be ignored.
    launch(5'b00100, 4'd2, 4'd1, 32'h1000, 1'b0, 4);
    chk("busy_after_start", 96'(busy), 96'(1'b1));
    tex_meta = {32'hDEAD_0000, 19'd0, 4'd1, 4'd1, 5'b00010};
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy_no_err", 96'(err), 96'(1'b0));
    finish_upload(8);
    chk("rgba_first", 96'(obs_addr[0]), 96'(32'h1000));
    chk("rgba_last", 96'(obs_addr[7]), 96'(32'h101C));

    // RGB_24 linear.
    launch(5'b00000, 4'd2, 4'd0, 32'h2000, 1'b0, 3);
    finish_upload(4);
    chk("rgb24_a1", 96'(obs_addr[1]), 96'(32'h2003));
    chk("rgb24_a3", 96'(obs_addr[3]), 96'(32'h2009));

    // R_8 tiled 32x16.
    launch(5'b10011, 4'd5, 4'd4, 32'h0, 1'b1, 1);
    finish_upload(512);
    chk("tile_x16_y0", 96'(obs_addr[16]), 96'(32'h100));
    chk("tile_x0_y1", 96'(obs_addr[32]), 96'(32'h010));
    chk("tile_x17_y3", 96'(obs_addr[113]), 96'(32'h131));

    // Backpressure: 5-cycle write stall mid-stream.
    launch(5'b00100, 4'd3, 4'd2, 32'h4000, 1'b0, 4);
    repeat (6) tick();
    wr_ready = 1'b0;
    tick();
    held_addr = wr_addr;
    held_data = wr_data;
    chk("stall_wr_valid", 96'(wr_valid), 96'(1'b1));
    chk("stall_in_ready", 96'(in_ready), 96'(1'b0));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_addr_hold", 96'(wr_addr), 96'(held_addr));
      chk("stall_data_hold", 96'(wr_data), 96'(held_data));
      chk("stall_in_ready", 96'(in_ready), 96'(1'b0));
    end
    wr_ready = 1'b1;
    base_cnt = wr_cnt;
    repeat (8) tick();
    chk("full_rate", 96'(wr_cnt - base_cnt), 96'(8));
    finish_upload(32);

    // Rejected descriptors.
    tex_meta = {32'h0, 19'd0, 4'd2, 4'd2, 5'b00010};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("etc2_err", 96'(err), 96'(1'b1));
    chk("etc2_busy", 96'(busy), 96'(1'b0));
    chk("etc2_in_ready", 96'(in_ready), 96'(1'b0));
    tick();
    chk("etc2_err_pulse", 96'(err), 96'(1'b0));
    tex_meta = {32'h0, 19'd0, 4'd3, 4'd4, 5'b10011};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tiled_small_err", 96'(err), 96'(1'b1));
    chk("tiled_small_busy", 96'(busy), 96'(1'b0));
    tick();

    // Reset mid-upload, then a clean restart.
    launch(5'b00100, 4'd2, 4'd1, 32'h3000, 1'b0, 4);
    for (int k = 0; k < 100 && wr_cnt < 3; k++) tick();
    chk("pre_rst_writes", 96'(wr_cnt >= 3), 96'(1'b1));
    rst  = 1'b1;
    feed = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("rst_mid_wr_valid", 96'(wr_valid), 96'(1'b0));
    chk("rst_mid_busy", 96'(busy), 96'(1'b0));
    chk("rst_mid_done", 96'(done), 96'(1'b0));
    tick();
    chk("rst_mid_no_done", 96'(done), 96'(1'b0));
    launch(5'b00100, 4'd2, 4'd1, 32'h3000, 1'b0, 4);
    finish_upload(8);
    chk("restart_addr", 96'(obs_addr[0]), 96'(32'h3000));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
